// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MUL   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic slice (ADD/SUB/AND/OR/XOR/SLT) with flag generation.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result_c,
    output alu_flags_t       flags_c
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Extra top bit carries the carry-out of ADD and the unsigned borrow of SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_c = '0;
        flags_c  = '0;
        case (op)
            OP_ADD: begin
                result_c         = sum[WIDTH-1:0];
                flags_c.carry    = sum[WIDTH];
                flags_c.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result_c         = diff[WIDTH-1:0];
                flags_c.carry    = diff[WIDTH];
                flags_c.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_XOR: result_c = a ^ b;
            OP_SLT: result_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result_c = '0;
        endcase
        flags_c.zero     = (result_c == '0);
        flags_c.negative = result_c[MSB];
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Handshaked multi-cycle ALU: single-cycle ops, iterative shifts and shift-add multiply.
// Optional multiplier is compiled only when ALU_MUL_EN is defined.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Controle_ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado_ALU,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;
    logic             err_q, err_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] comb_res;
    alu_flags_t       comb_flags;
    logic [SHW-1:0]   amt;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

    assign amt = B[SHW-1:0];

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (A),
        .b        (B),
        .op       (Controle_ALUop),
        .result_c (comb_res),
        .flags_c  (comb_flags)
    );

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [3:0] op);
        case (op)
            OP_SLL:  shift_one = v << 1;
            OP_SRA:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_one = v >> 1;
        endcase
    endfunction

    function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c);
        mk_flags          = '0;
        mk_flags.zero     = (r == '0);
        mk_flags.carry    = c;
        mk_flags.negative = r[WIDTH-1];
    endfunction

    // Next-state and datapath; the first shift/multiply step is taken on the accept edge.
    always_comb begin
        logic [WIDTH-1:0] sh_step;
`ifdef ALU_MUL_EN
        logic [2*WIDTH-1:0] prod_step;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_step = '0;
`endif
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sh_step = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = Controle_ALUop;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                    case (Controle_ALUop)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                            res_d   = comb_res;
                            flags_d = comb_flags;
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            sh_step = shift_one(A, Controle_ALUop);
                            if (amt == '0) begin
                                res_d   = A;
                                flags_d = mk_flags(A, 1'b0);
                            end else if (amt == SHW'(1)) begin
                                res_d   = sh_step;
                                flags_d = mk_flags(sh_step, 1'b0);
                            end else begin
                                sh_d    = sh_step;
                                cnt_d   = amt - SHW'(1);
                                state_d = ST_SHIFT;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            prod_d   = B[0] ? {{WIDTH{1'b0}}, A} : '0;
                            mcand_d  = {{(WIDTH-1){1'b0}}, A, 1'b0};
                            mplier_d = B >> 1;
                            cnt_d    = SHW'(WIDTH - 1);
                            state_d  = ST_MUL;
                        end
`endif
                        default: begin
                            res_d         = '0;
                            flags_d       = '0;
                            flags_d.zero  = 1'b1;
                            err_d         = 1'b1;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_step = shift_one(sh_q, op_q);
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = sh_step;
                    flags_d = mk_flags(sh_step, 1'b0);
                    state_d = ST_DONE;
                end else begin
                    sh_d = sh_step;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
                cnt_d     = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = prod_step[WIDTH-1:0];
                    flags_d = mk_flags(prod_step[WIDTH-1:0], |prod_step[2*WIDTH-1:WIDTH]);
                    state_d = ST_DONE;
                end else begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            op_q     <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
`ifdef ALU_MUL_EN
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
`ifdef ALU_MUL_EN
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign in_ready      = (state_q == ST_IDLE) && !rst;
    assign out_valid     = (state_q == ST_DONE);
    assign resultado_ALU = res_q;
    assign zero          = flags_q.zero;
    assign carry         = flags_q.carry;
    assign overflow      = flags_q.overflow;
    assign negative      = flags_q.negative;
    assign err           = err_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo (WIDTH=8); expectations follow ALU_MUL_EN if defined.
module tb_alu_multiciclo;
    import alu_pkg::*;

    logic       clk, rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] A, B, resultado_ALU;
    logic [3:0] Controle_ALUop;
    logic       zero, carry, overflow, negative, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic       z, c, o, n, e;
        int         lat;
    } exp_t;

    exp_t sb[$];

    alu_multiciclo #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .A              (A),
        .B              (B),
        .Controle_ALUop (Controle_ALUop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .resultado_ALU  (resultado_ALU),
        .zero           (zero),
        .carry          (carry),
        .overflow       (overflow),
        .negative       (negative),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one transaction.
    function automatic exp_t model(input string tag, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] op);
        exp_t       e;
        logic [15:0] p;
        e.tag = tag; e.res = 8'h00; e.z = 1'b0; e.c = 1'b0; e.o = 1'b0; e.n = 1'b0;
        e.e = 1'b0; e.lat = 1;
        p = 16'h0;
        case (op)
            OP_ADD: begin
                {e.c, e.res} = {1'b0, a} + {1'b0, b};
                e.o = (a[7] == b[7]) && (e.res[7] != a[7]);
            end
            OP_SUB: begin
                e.res = a - b;
                e.c   = (a < b);
                e.o   = (a[7] != b[7]) && (e.res[7] != a[7]);
            end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_SLT: e.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            OP_SLL: begin e.res = a << b[2:0]; e.lat = (b[2:0] == 3'd0) ? 1 : int'(b[2:0]); end
            OP_SRL: begin e.res = a >> b[2:0]; e.lat = (b[2:0] == 3'd0) ? 1 : int'(b[2:0]); end
            OP_SRA: begin
                e.res = 8'($signed(a) >>> b[2:0]);
                e.lat = (b[2:0] == 3'd0) ? 1 : int'(b[2:0]);
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                p     = {8'h00, a} * {8'h00, b};
                e.res = p[7:0];
                e.c   = (p[15:8] != 8'h00);
                e.lat = 8;
            end
`endif
            default: e.e = 1'b1;
        endcase
        e.z = (e.res == 8'h00);
        e.n = e.res[7];
        return e;
    endfunction

    // Drive one transaction at a negedge; returns just after its accept edge with inputs scrambled.
    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input bit push);
        if (push) sb.push_back(model(tag, a, b, op));
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; Controle_ALUop = op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = ~a; B = ~b; Controle_ALUop = ~op;
    endtask

    task automatic collect();
        exp_t e;
        int   lat;
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".res"}, 32'(resultado_ALU), 32'(e.res));
            check({e.tag, ".zero"}, 32'(zero), 32'(e.z));
            check({e.tag, ".carry"}, 32'(carry), 32'(e.c));
            check({e.tag, ".ovf"}, 32'(overflow), 32'(e.o));
            check({e.tag, ".neg"}, 32'(negative), 32'(e.n));
            check({e.tag, ".err"}, 32'(err), 32'(e.e));
            check({e.tag, ".lat"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("release.out_valid", 32'(out_valid), 32'd0);
        check("release.in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op);
        issue(tag, a, b, op, 1'b1);
        collect();
        release_out();
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 8'h00; B = 8'h00; Controle_ALUop = 4'h0;

        repeat (2) @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.res", 32'(resultado_ALU), 32'd0);
        check("rst.flags", 32'({zero, carry, overflow, negative, err}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        run_op("add_f0_20", 8'hF0, 8'h20, OP_ADD);
        run_op("sub_80_01", 8'h80, 8'h01, OP_SUB);
        run_op("sub_05_05", 8'h05, 8'h05, OP_SUB);
        run_op("sll_01_3", 8'h01, 8'h03, OP_SLL);
        run_op("sra_80_7", 8'h80, 8'h07, OP_SRA);
        run_op("srl_80_0", 8'h80, 8'h00, OP_SRL);
        run_op("mul_0f_11", 8'h0F, 8'h11, OP_MUL);
        run_op("mul_10_10", 8'h10, 8'h10, OP_MUL);
        run_op("illegal_c", 8'h12, 8'h34, 4'b1100);
        run_op("slt_ff_01", 8'hFF, 8'h01, OP_SLT);

        // Backpressure: result held while out_ready is low, new requests ignored.
        issue("xor_bp", 8'h5A, 8'h0F, OP_XOR, 1'b1);
        collect();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = 8'hFF; B = 8'h01; Controle_ALUop = OP_ADD;
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.res", 32'(resultado_ALU), 32'h55);
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("bp.no_ghost", 32'(seen), 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            run_op($sformatf("rnd%0d_op%0h", i, op), a, b, op);
        end

        // Leave nonzero outputs behind, then abort a long op with reset.
        run_op("add_7f_01", 8'h7F, 8'h01, OP_ADD);
`ifdef ALU_MUL_EN
        issue("abort_mul", 8'h0F, 8'h11, OP_MUL, 1'b0);
`else
        issue("abort_sll", 8'h01, 8'h07, OP_SLL, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort.in_ready", 32'(in_ready), 32'd0);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.res", 32'(resultado_ALU), 32'd0);
        check("abort.flags", 32'({zero, carry, overflow, negative, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.in_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort.no_out_valid", 32'(seen), 32'd0);
        run_op("after_abort", 8'h33, 8'h11, OP_SUB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
